// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-ported RAM between an instruction requester and a data
// requester. An FSM grants one side at a time, latches that side's operands
// on grant and presents them to the RAM until the RAM reports ACCESS. It also
// handles requester aborts, RAM errors and a per-access timeout.
//
// Ports
//   CLK, nRST       system clock (rising edge), asynchronous active-low reset
//   iREN            instruction read request
//   dREN, dWEN      data read / write request
//   iaddr, daddr    instruction / data word address
//   dstore          data write value
//   ramstate        RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3
//   ramload         RAM read data
//   iwait, dwait    access not complete; low for one cycle on completion
//   iload, dload    read data, non-zero only in the completion cycle
//   ramREN, ramWEN  RAM strobes
//   ramaddr         RAM address
//   ramstore        RAM write data
//   mem_err         sticky fault flag (illegal request or RAM fault/timeout)
// -----------------------------------------------------------------------------
module mem_arbiter #(
  // Access cycles allowed before an unfinished access is declared failed.
  // The cycle counter is 5 bits wide, so values above 31 are not meaningful.
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] iaddr,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  input  logic [1:0]  ramstate,
  input  logic [31:0] ramload,
  output logic        iwait,
  output logic        dwait,
  output logic [31:0] iload,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  output logic        mem_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DACC = 2'd1,
    S_IACC = 2'd2,
    S_ERR  = 2'd3
  } state_e;

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  localparam logic [4:0] TIMEOUT_C  = 5'(TIMEOUT);
  localparam logic [4:0] CNT_MAX    = 5'h1f;

  state_e      state_q,  state_d;
  logic [4:0]  cnt_q,    cnt_d;
  logic        ifirst_q, ifirst_d;
  logic        err_q,    err_d;
  logic [31:0] addr_q,   addr_d;
  logic [31:0] store_q,  store_d;
  logic        wen_q,    wen_d;

  logic        dreq;
  logic        owner_req;
  logic [4:0]  cnt_inc;

  assign dreq      = dREN | dWEN;
  // Live request of whichever side currently owns the RAM; dropping it aborts.
  assign owner_req = (state_q == S_DACC) ? dreq : iREN;
  assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 5'd1;

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ifirst_d = ifirst_q;
    err_d    = err_q;
    addr_d   = addr_q;
    store_d  = store_q;
    wen_d    = wen_q;

    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = '0;
    dload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;

    unique case (state_q)
      S_IDLE: begin
        // Data normally wins; after a data completion the instruction side
        // gets the next grant if it is waiting (ifirst).
        if (dreq && !(ifirst_q && iREN)) begin
          state_d = S_DACC;
          cnt_d   = '0;
          addr_d  = daddr;
          store_d = dstore;
          wen_d   = dWEN;
          // Read and write at once is illegal: flag it and perform the write.
          if (dREN && dWEN) err_d = 1'b1;
        end else if (iREN) begin
          state_d = S_IACC;
          cnt_d   = '0;
          addr_d  = iaddr;
          store_d = '0;
          wen_d   = 1'b0;
        end
      end

      S_DACC, S_IACC: begin
        // RAM sees only the operands latched at grant; requester changes
        // during the access are ignored.
        ramREN   = ~wen_q;
        ramWEN   = wen_q;
        ramaddr  = addr_q;
        ramstore = store_q;
        cnt_d    = cnt_inc;

        if (ramstate == RAM_ERROR) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end else if (!owner_req) begin
          // Abort: no wait pulse and fairness state untouched.
          state_d = S_IDLE;
        end else if (ramstate == RAM_ACCESS) begin
          state_d = S_IDLE;
          if (state_q == S_DACC) begin
            dwait    = 1'b0;
            dload    = wen_q ? '0 : ramload;
            ifirst_d = 1'b1;
          end else begin
            iwait    = 1'b0;
            iload    = ramload;
            ifirst_d = 1'b0;
          end
        end else if (cnt_inc >= TIMEOUT_C) begin
          // cnt_inc counts access cycles including this one.
          state_d = S_ERR;
          err_d   = 1'b1;
        end
      end

      S_ERR: begin
        // Terminal until reset; outputs stay at their idle defaults.
        state_d = S_ERR;
      end

      default: begin
        state_d = S_ERR;
        err_d   = 1'b1;
      end
    endcase
  end

  assign mem_err = err_q;

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values computed above, independent of statement order.
  // NOTE: the operand registers are reset too, so RAM-facing values are a
  // known zero out of reset rather than whatever powered up.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      ifirst_q <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      store_q  <= '0;
      wen_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ifirst_q <= ifirst_d;
      err_q    <= err_d;
      addr_q   <= addr_d;
      store_q  <= store_d;
      wen_q    <= wen_d;
    end
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, the number of cycles in an access state after which an unfinished RAM access is declared failed.
REQ-002 SHALL use clock and reset: CLK  input  1  system clock, rising edge.
REQ-003 SHALL use clock and reset: nRST  input  1  asynchronous active-low reset.
REQ-004 SHALL have iREN  input  1  instruction read request, from request unit imemREN.
REQ-005 SHALL have dREN  input  1  data read request, from request unit dmemREN.
REQ-006 SHALL have dWEN  input  1  data write request, from request unit dmemWEN.
REQ-007 SHALL have iaddr  input  32  instruction word address.
REQ-008 SHALL have daddr  input  32  data word address.
REQ-009 SHALL have dstore  input  32  data write value.
REQ-010 SHALL have ramstate  input  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3.
REQ-011 SHALL have ramload  input  32  RAM read data.
REQ-012 SHALL have iwait  output  1  instruction access not complete; 0 for exactly one cycle on completion.
REQ-013 SHALL have dwait  output  1  data access not complete; 0 for exactly one cycle on completion.
REQ-014 SHALL have iload, dload  output  32 each  read data, valid in the completion cycle only.
REQ-015 SHALL have ramREN, ramWEN  output  1 each  RAM strobes.
REQ-016 SHALL have ramaddr, ramstore  output  32 each  RAM address and write data.
REQ-017 SHALL have mem_err  output  1  sticky fault flag.

Function
REQ-018 SHALL implement an FSM with states IDLE, DACC, IACC, ERR.
REQ-019 IDLE: all RAM strobes 0, iwait=dwait=1.
REQ-020 Exit from IDLE: dREN|dWEN -> DACC; else iREN -> IACC; else stay in IDLE.
REQ-021 When both sides are pending and the ifirst flag is set, IDLE SHALL grant IACC instead of DACC.
REQ-022 On entry to an access state, SHALL register the address, store data, and op (read/write) of the granted side.
REQ-023 SHALL drive ramaddr, ramstore, ramREN, and ramWEN from those registers while in the access state.
REQ-024 dREN&dWEN both 1 at grant: SHALL perform a write and set mem_err; the FSM continues normally.
REQ-025 Completion: in DACC/IACC with ramstate==ACCESS, SHALL drop the owner's wait to 0 that cycle.
REQ-026 The completion cycle SHALL pass ramload combinationally to the owner's load output on reads, then return to IDLE.
REQ-027 Minimum latency: request first seen high at edge n -> wait low in cycle n+1 if RAM answers ACCESS immediately.
REQ-028 ramstate BUSY or FREE in an access state: hold state and outputs.
REQ-029 Each cycle in an access state, SHALL increment a 5-bit saturating cycle counter; the counter clears on entry to any access state.
REQ-030 Counter reaching TIMEOUT without completion -> ERR.
REQ-031 ramstate==ERROR in an access state -> ERR.
REQ-032 Owner request deasserted mid-access: abort to IDLE next edge, strobes 0, no wait pulse, no ifirst update.
REQ-033 ifirst SHALL set on a DACC completion and clear on an IACC completion.
REQ-034 Requesters SHALL hold request and operands stable until wait is low; changed operands mid-access SHALL be ignored.
REQ-035 ERR: strobes 0, iwait=dwait=1, mem_err=1; ERR SHALL be left only by reset.
REQ-036 Load outputs SHALL be 0 outside their completion cycle.

Reset
REQ-037 nRST low SHALL asynchronously force IDLE, counter=0, ifirst=0, and mem_err=0.
REQ-038 nRST low SHALL also clear the operand registers to 0.
REQ-039 While in reset, outputs SHALL read iwait=dwait=1, ramREN=ramWEN=0, and ramaddr=ramstore=iload=dload=0.
REQ-040 Reset asserted mid-access SHALL drop the strobes immediately, without waiting for a clock edge.
REQ-041 Reset release SHALL be followed by IDLE behaviour on the first edge.

Verification
REQ-042 Instruction read: iREN=1, iaddr=0x00000040; ramstate BUSY 2 cycles, then ACCESS with ramload=0x8C220004 -> ramREN=1 and ramaddr=0x40 throughout; iwait=0 and iload=0x8C220004 for one cycle; then IDLE.
REQ-043 Contention and fairness: iREN=dREN=1 held -> data served first; after dwait pulse the instruction is served next even with dREN still high; then data again.
REQ-044 Write path: dWEN=1, daddr=0x100, dstore=0xDEADBEEF, ramstate ACCESS after 1 cycle -> ramWEN=1, ramstore=0xDEADBEEF, dwait=0 one cycle, dload=0.
REQ-045 Timeout: iREN=1, ramstate stuck BUSY -> ERR after exactly 15 access cycles; mem_err=1 sticky; later requests ignored until nRST pulse.
REQ-046 Abort and reset: drop dREN mid-access -> IDLE with no dwait pulse; assert nRST mid-IACC -> ramREN=0 immediately and all outputs at reset values.
